// File: rtl/axi_sram_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_sram_slave_if
// Description : AXI read/write channel bundle between the core arbiter and
//               the on-chip burst memory model.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_sram_slave_if #(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32
);
    logic                  AWVALID;
    logic                  AWREADY;
    logic [3:0]            AWID;
    logic [3:0]            AWLEN;
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic                  WVALID;
    logic                  WREADY;
    logic                  WLAST;
    logic [3:0]            WID;
    logic [DATA_WIDTH-1:0] WDATA;
    logic                  BVALID;
    logic                  BREADY;
    logic [3:0]            BID;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [3:0]            ARID;
    logic [3:0]            ARLEN;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic                  RVALID;
    logic                  RREADY;
    logic                  RLAST;
    logic [3:0]            RID;
    logic [DATA_WIDTH-1:0] RDATA;

    modport slave (
        input  AWVALID, AWID, AWLEN, AWADDR,
        input  WVALID, WLAST, WID, WDATA,
        input  BREADY,
        input  ARVALID, ARID, ARLEN, ARADDR,
        input  RREADY,
        output AWREADY, WREADY, BVALID, BID,
        output ARREADY, RVALID, RLAST, RID, RDATA
    );

    modport master (
        output AWVALID, AWID, AWLEN, AWADDR,
        output WVALID, WLAST, WID, WDATA,
        output BREADY,
        output ARVALID, ARID, ARLEN, ARADDR,
        output RREADY,
        input  AWREADY, WREADY, BVALID, BID,
        input  ARREADY, RVALID, RLAST, RID, RDATA
    );
endinterface
`default_nettype wire

// File: rtl/axi_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi_sram_slave
// Description : AXI burst memory model with independent read and write FSMs.
//               Define AXI_SLV_PROTOCOL_CHECK_EN to build the sticky W-channel
//               protocol checker driving protocol_err.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_sram_slave #(
    parameter int ADDR_WIDTH   = 26,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH_LOG2   = 14,
    parameter int READ_LATENCY = 2
) (
    input  wire logic       clk,
    input  wire logic       rst,
    axi_sram_slave_if.slave bus,
    output logic            protocol_err
);
    localparam int                    c_depth   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] c_idx_one = 1;

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_BURST = 2'd2} rstate_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;

    logic [DATA_WIDTH-1:0] mem [c_depth];

    rstate_t               r_rstate, w_rnext;
    logic [DEPTH_LOG2-1:0] r_ridx;
    logic [3:0]            r_rlen, r_rbeat, r_rid, r_lat_cnt;
    logic                  r_arready, r_rvalid, r_rhold;
    logic [DATA_WIDTH-1:0] r_rdata_hold;
    logic [DATA_WIDTH-1:0] w_rdata_live;
    logic                  w_ar_hs, w_r_hs;

    wstate_t               r_wstate, w_wnext;
    logic [DEPTH_LOG2-1:0] r_widx;
    logic [3:0]            r_wlen, r_wbeat, r_wid;
    logic                  r_awready, r_wready, r_bvalid;
    logic                  w_aw_hs, w_w_hs, w_b_hs;

    logic                  unused_addr_bits;

    assign w_ar_hs = bus.ARVALID && r_arready;
    assign w_r_hs  = r_rvalid && bus.RREADY;
    assign w_aw_hs = bus.AWVALID && r_awready;
    assign w_w_hs  = bus.WVALID && r_wready;
    assign w_b_hs  = r_bvalid && bus.BREADY;

    // Only the word-index bits of the byte addresses are meaningful.
    assign unused_addr_bits = ^{bus.ARADDR, bus.AWADDR};

    // ------------------------------------------------------------------ read
    always_comb begin
        w_rnext = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rnext = R_WAIT;
            R_WAIT:  if (r_lat_cnt == 4'd0) w_rnext = R_BURST;
            R_BURST: if (w_r_hs && (r_rbeat == r_rlen)) w_rnext = R_IDLE;
            default: w_rnext = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rstate     <= R_IDLE;
            r_arready    <= 1'b0;
            r_rvalid     <= 1'b0;
            r_ridx       <= '0;
            r_rlen       <= 4'd0;
            r_rbeat      <= 4'd0;
            r_rid        <= 4'd0;
            r_lat_cnt    <= 4'd0;
            r_rhold      <= 1'b0;
            r_rdata_hold <= '0;
        end else begin
            r_rstate  <= w_rnext;
            r_arready <= (w_rnext == R_IDLE);
            r_rvalid  <= (w_rnext == R_BURST);
            if (w_ar_hs) begin
                r_rid     <= bus.ARID;
                r_ridx    <= bus.ARADDR[DEPTH_LOG2+1:2];
                r_rlen    <= bus.ARLEN;
                r_rbeat   <= 4'd0;
                r_lat_cnt <= 4'(READ_LATENCY);
            end
            if ((r_rstate == R_WAIT) && (r_lat_cnt != 4'd0))
                r_lat_cnt <= r_lat_cnt - 4'd1;
            if (w_r_hs) begin
                r_ridx  <= r_ridx + c_idx_one;
                r_rbeat <= r_rbeat + 4'd1;
            end
            // A stalled beat freezes the word it first presented, so later
            // writes to that word do not disturb RDATA mid-stall.
            r_rhold <= r_rvalid && !bus.RREADY;
            if (r_rvalid && !bus.RREADY && !r_rhold)
                r_rdata_hold <= w_rdata_live;
        end
    end

    assign w_rdata_live = mem[r_ridx];
    assign bus.ARREADY  = r_arready;
    assign bus.RVALID   = r_rvalid;
    assign bus.RID      = r_rid;
    assign bus.RLAST    = r_rvalid && (r_rbeat == r_rlen);
    assign bus.RDATA    = !r_rvalid ? '0 : (r_rhold ? r_rdata_hold : w_rdata_live);

    // ----------------------------------------------------------------- write
    always_comb begin
        w_wnext = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_aw_hs) w_wnext = W_DATA;
            W_DATA:  if (w_w_hs && (r_wbeat == r_wlen)) w_wnext = W_RESP;
            W_RESP:  if (w_b_hs) w_wnext = W_IDLE;
            default: w_wnext = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_widx    <= '0;
            r_wlen    <= 4'd0;
            r_wbeat   <= 4'd0;
            r_wid     <= 4'd0;
        end else begin
            r_wstate  <= w_wnext;
            r_awready <= (w_wnext == W_IDLE);
            r_wready  <= (w_wnext == W_DATA);
            r_bvalid  <= (w_wnext == W_RESP);
            if (w_aw_hs) begin
                r_wid   <= bus.AWID;
                r_widx  <= bus.AWADDR[DEPTH_LOG2+1:2];
                r_wlen  <= bus.AWLEN;
                r_wbeat <= 4'd0;
            end
            if (w_w_hs) begin
                r_widx  <= r_widx + c_idx_one;
                r_wbeat <= r_wbeat + 4'd1;
            end
        end
    end

    // Array has no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (w_w_hs)
            mem[r_widx] <= bus.WDATA;
    end

    assign bus.AWREADY = r_awready;
    assign bus.WREADY  = r_wready;
    assign bus.BVALID  = r_bvalid;
    assign bus.BID     = r_wid;

    // --------------------------------------------------------- protocol check
`ifdef AXI_SLV_PROTOCOL_CHECK_EN
    logic w_err_wlast, w_err_wid, w_err_idle, r_perr;

    assign w_err_wlast = w_w_hs && (bus.WLAST != (r_wbeat == r_wlen));
    assign w_err_wid   = w_w_hs && (bus.WID != r_wid);
    assign w_err_idle  = bus.WVALID && (r_wstate == W_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_perr <= 1'b0;
        else if (w_err_wlast || w_err_wid || w_err_idle)
            r_perr <= 1'b1;
    end

`ifdef SIMULATION
    always @(posedge clk) begin
        if (!rst) begin
            if (w_err_wlast) $error("axi_sram_slave: WLAST does not match expected last beat");
            if (w_err_wid)   $error("axi_sram_slave: WID differs from latched AWID");
            if (w_err_idle)  $error("axi_sram_slave: WVALID asserted with no write burst open");
        end
    end
`endif

    assign protocol_err = r_perr;
`else
    logic unused_wchk;
    assign unused_wchk  = ^{bus.WLAST, bus.WID};
    assign protocol_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_slave.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_axi_sram_slave
// Description : Self-checking bench: vector table, hand sequences and random
//               bursts against a flat word-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_sram_slave;
    localparam int AW = 26;
    localparam int DW = 32;
    localparam int DL = 8;
    localparam int RL = 2;
    localparam int NW = 1 << DL;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic protocol_err;

    axi_sram_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_sram_slave #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .DEPTH_LOG2  (DL),
        .READ_LATENCY(RL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] mm [NW];

    typedef struct {
        logic [25:0] addr;
        int          len;
        logic [3:0]  id;
        logic [31:0] data0;
        int          exp_first;
        int          exp_last;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int widx(input logic [25:0] a, input int k);
        return (int'(a >> 2) + k) % NW;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [25:0] addr, input int len, input logic [3:0] id,
                            input logic [31:0] data [16], input int gap_pct,
                            input int bready_dly, input bit bad_last);
        int t;
        bus.AWVALID = 1'b1; bus.AWADDR = addr; bus.AWLEN = 4'(len); bus.AWID = id;
        t = 0;
        while (!bus.AWREADY && t < 50) begin tick(); t++; end
        if (t >= 50) check("aw_timeout", 1, 0);
        tick();
        bus.AWVALID = 1'b0;
        for (int k = 0; k <= len; k++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                bus.WVALID = 1'b0;
                tick();
            end
            bus.WVALID = 1'b1; bus.WDATA = data[k]; bus.WID = id;
            bus.WLAST  = bad_last ? (k == 0) : (k == len);
            t = 0;
            while (!bus.WREADY && t < 50) begin tick(); t++; end
            if (t >= 50) check("w_timeout", 1, 0);
            tick();
            mm[widx(addr, k)] = data[k];
        end
        bus.WVALID = 1'b0; bus.WLAST = 1'b0;
        check("bvalid_after_last_w", bus.BVALID, 1);
        check("bid", bus.BID, id);
        for (int i = 0; i < bready_dly; i++) begin
            tick();
            check("bvalid_held", bus.BVALID, 1);
        end
        bus.BREADY = 1'b1;
        tick();
        bus.BREADY = 1'b0;
        check("bvalid_drop", bus.BVALID, 0);
        check("awready_back", bus.AWREADY, 1);
    endtask

    // mode: 0 = RREADY held high, 1 = toggle 1,0,1,.., 2 = random
    task automatic do_read(input logic [25:0] addr, input int len, input logic [3:0] id,
                           input int mode, input string tag, output logic [31:0] first);
        int t, k, cyc;
        bit rr, tog;
        first = '0;
        bus.ARVALID = 1'b1; bus.ARADDR = addr; bus.ARLEN = 4'(len); bus.ARID = id;
        t = 0;
        while (!bus.ARREADY && t < 50) begin tick(); t++; end
        if (t >= 50) check({tag, "_ar_timeout"}, 1, 0);
        tick();
        bus.ARVALID = 1'b0;
        t = 0;
        while (!bus.RVALID && t < 40) begin tick(); t++; end
        check({tag, "_latency"}, t, RL + 1);
        k = 0; cyc = 0; tog = 1'b1;
        while (k <= len && cyc < 200) begin
            rr  = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(1));
            tog = !tog;
            bus.RREADY = rr;
            check({tag, "_rvalid"}, bus.RVALID, 1);
            check({tag, "_rdata"}, bus.RDATA, mm[widx(addr, k)]);
            check({tag, "_rlast"}, bus.RLAST, (k == len));
            check({tag, "_rid"}, bus.RID, id);
            if (k == 0) first = bus.RDATA;
            if (rr) k++;
            tick();
            cyc++;
        end
        bus.RREADY = 1'b0;
        check({tag, "_beats"}, k, len + 1);
        check({tag, "_rvalid_drop"}, bus.RVALID, 0);
        check({tag, "_arready_back"}, bus.ARREADY, 1);
    endtask

    initial begin
        vec_t        vec [5];
        logic [31:0] d [16];
        logic [31:0] got, d2;
        logic [25:0] ra, wa;
        int          n;

        vec[0] = '{26'h0000040, 0,  4'h3, 32'hDEADBEEF, 16,  16};
        vec[1] = '{26'h0000100, 3,  4'h5, 32'h00000001, 64,  67};
        vec[2] = '{26'h00003F8, 2,  4'h7, 32'hC0DE0000, 254, 0};
        vec[3] = '{26'h02A55A7, 4,  4'hA, 32'h55AA0000, 105, 109};
        vec[4] = '{26'h00003FC, 15, 4'hE, 32'h12340000, 255, 14};

        bus.AWVALID = 0; bus.AWID = 0; bus.AWLEN = 0; bus.AWADDR = 0;
        bus.WVALID = 0; bus.WLAST = 0; bus.WID = 0; bus.WDATA = 0; bus.BREADY = 0;
        bus.ARVALID = 0; bus.ARID = 0; bus.ARLEN = 0; bus.ARADDR = 0; bus.RREADY = 0;

        // Reset state
        #2 rst = 1'b1;
        repeat (3) tick();
        check("rst_arready", bus.ARREADY, 0);
        check("rst_awready", bus.AWREADY, 0);
        check("rst_wready", bus.WREADY, 0);
        check("rst_bvalid", bus.BVALID, 0);
        check("rst_rvalid", bus.RVALID, 0);
        check("rst_rlast", bus.RLAST, 0);
        check("rst_rdata", bus.RDATA, 0);
        check("rst_ids", {bus.BID, bus.RID}, 0);
        check("rst_perr", protocol_err, 0);
        rst = 1'b0;
        tick();
        check("post_rst_arready", bus.ARREADY, 1);
        check("post_rst_awready", bus.AWREADY, 1);

        // Fill memory so every model word is defined
        for (int b = 0; b < NW / 16; b++) begin
            for (int k = 0; k < 16; k++) d[k] = $urandom;
            do_write(26'(b * 64), 15, 4'(b), d, 0, 0, 1'b0);
        end

        // Table vectors: write a burst, then read back the first and last word
        // at the hand-computed word indices.
        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < 16; k++) d[k] = vec[v].data0 + 32'(k);
            do_write(vec[v].addr, vec[v].len, vec[v].id, d, 0, v % 3, 1'b0);
            do_read(26'(vec[v].exp_first * 4), 0, vec[v].id, 0, "vec_first", got);
            check("vec_first_word", got, vec[v].data0);
            do_read(26'(vec[v].exp_last * 4), 0, vec[v].id, 0, "vec_last", got);
            check("vec_last_word", got, vec[v].data0 + 32'(vec[v].len));
        end

        // 4-beat write of 1..4 then toggling-RREADY read
        for (int k = 0; k < 16; k++) d[k] = 32'(k + 1);
        do_write(26'h100, 3, 4'h2, d, 0, 0, 1'b0);
        do_read(26'h100, 3, 4'h6, 1, "toggle", got);
        check("toggle_first", got, 32'd1);

        // Concurrent AR + AW in the same cycle
        for (int k = 0; k < 16; k++) d[k] = 32'hBEEF0000 + 32'(k);
        fork
            do_read(26'h200, 3, 4'hC, 0, "conc_rd", got);
            do_write(26'h300, 3, 4'hD, d, 0, 1, 1'b0);
        join
        do_read(26'h300, 3, 4'h1, 0, "conc_chk", got);
        check("conc_wr_first", got, 32'hBEEF0000);

        // Reset in the middle of a read burst
        bus.ARVALID = 1'b1; bus.ARADDR = 26'h80; bus.ARLEN = 4'd3; bus.ARID = 4'h4;
        tick();
        bus.ARVALID = 1'b0;
        n = 0;
        while (!bus.RVALID && n < 40) begin tick(); n++; end
        check("rstmid_latency", n, RL + 1);
        bus.RREADY = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        check("rstmid_rvalid", bus.RVALID, 0);
        check("rstmid_arready", bus.ARREADY, 0);
        check("rstmid_rdata", bus.RDATA, 0);
        repeat (2) tick();
        rst = 1'b0;
        bus.RREADY = 1'b0;
        tick();
        check("rstmid_arready_back", bus.ARREADY, 1);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.RVALID) n++;
            tick();
        end
        check("rstmid_stray_beats", n, 0);
        do_read(26'h80, 3, 4'h4, 0, "rstmid_mem", got);

        // Randomized bursts against the model
        for (int it = 0; it < 25; it++) begin
            wa = 26'($urandom);
            n  = $urandom_range(15);
            for (int k = 0; k < 16; k++) d[k] = $urandom;
            do_write(wa, n, 4'($urandom), d, 30, $urandom_range(3), 1'b0);
            ra = ($urandom_range(1) == 1) ? wa : 26'($urandom);
            do_read(ra, $urandom_range(15), 4'($urandom), 2, "rand", got);
        end

        // Protocol violation: WLAST on the first of two beats
        check("perr_clean", protocol_err, 0);
        d[0] = 32'hA5A5A5A5; d[1] = 32'h5A5A5A5A;
        do_write(26'h20, 1, 4'h9, d, 0, 0, 1'b1);
        repeat (3) tick();
`ifdef AXI_SLV_PROTOCOL_CHECK_EN
        check("perr_set", protocol_err, 1);
`else
        check("perr_tied_low", protocol_err, 0);
`endif
        do_read(26'h20, 1, 4'h9, 0, "perr_rd", got);
        check("perr_wr_data", got, 32'hA5A5A5A5);
        d2 = 32'h0;
        for (int k = 0; k < 16; k++) d[k] = d2 + 32'(k);
        do_write(26'h60, 0, 4'h1, d, 0, 0, 1'b0);
`ifdef AXI_SLV_PROTOCOL_CHECK_EN
        check("perr_sticky", protocol_err, 1);
`else
        check("perr_still_low", protocol_err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
